// File: rtl/turn_ctrl.sv
// rtl/turn_ctrl.sv - game-flow phase sequencer driving the enemy block's state/turn/rotate inputs
module turn_ctrl #(
  parameter int ANIM_FRAMES          = 30,
  parameter int ENEMY_TIMEOUT_FRAMES = 120,
  parameter int MAX_TURN             = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       start_btn,
  input  logic       player_done,
  input  logic [1:0] player_rotate,
  input  logic       enemy_busy,
  input  logic       enemy_finished,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic [1:0] rotate_out,
  output logic       timeout_flag,
  output logic       game_over
);

  // Phase encodings double as the codes seen by the enemy block.
  typedef enum logic [3:0] {
    PH_TITLE       = 4'b0001,
    PH_PLAYER      = 4'b0010,
    PH_PLAYER_ANIM = 4'b0100,
    PH_ENEMY       = 4'b1000,
    PH_GAME_OVER   = 4'b1111
  } phase_t;

  // Last counter values before the animation / enemy phases end.
  localparam logic [7:0] ANIM_LAST    = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(ENEMY_TIMEOUT_FRAMES - 1);
  localparam logic [3:0] TURN_LIMIT   = 4'(MAX_TURN);

  phase_t     phase;
  // Only one phase is active at a time, so a single flag remembers the
  // trigger of the current phase until the next frame boundary.
  logic       pending;
  logic [7:0] frame_cnt;

  logic start_go;
  logic done_go;
  logic anim_go;
  logic enemy_normal;
  logic enemy_timeout;
  logic enemy_go;
  logic last_turn;

  assign state_out = phase;

  // A phase may only move on a frame boundary; a trigger in the same cycle counts.
  assign start_go      = frame_start && (pending || start_btn);
  assign done_go       = frame_start && (pending || player_done);
  assign anim_go       = frame_start && (frame_cnt == ANIM_LAST);
  // A busy enemy holds off a normal exit, but never the timeout.
  assign enemy_normal  = frame_start && (pending || enemy_finished) && !enemy_busy;
  assign enemy_timeout = frame_start && (frame_cnt == TIMEOUT_LAST);
  assign enemy_go      = enemy_normal || enemy_timeout;
  // turn_out stays below TURN_LIMIT until game over, so this sum cannot overflow.
  assign last_turn     = (turn_out + 4'd1) == TURN_LIMIT;

  // Phase sequencer with registered outputs, pending flag and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase        <= PH_TITLE;
      pending      <= 1'b0;
      frame_cnt    <= 8'd0;
      turn_out     <= 4'd0;
      rotate_out   <= 2'b00;
      timeout_flag <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      case (phase)
        PH_TITLE: begin
          if (start_go) begin
            phase   <= PH_PLAYER;
            pending <= 1'b0;
          end else if (start_btn) begin
            pending <= 1'b1;
          end
        end

        PH_PLAYER: begin
          // The most recent committed move decides the rotation.
          if (player_done) begin
            rotate_out <= player_rotate;
          end
          if (done_go) begin
            phase     <= PH_PLAYER_ANIM;
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
          end else if (player_done) begin
            pending <= 1'b1;
          end
        end

        PH_PLAYER_ANIM: begin
          if (anim_go) begin
            phase     <= PH_ENEMY;
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
          end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end

        PH_ENEMY: begin
          if (enemy_go) begin
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
            if (!enemy_normal) begin
              timeout_flag <= 1'b1;
            end
            if (last_turn) begin
              phase     <= PH_GAME_OVER;
              turn_out  <= TURN_LIMIT;
              game_over <= 1'b1;
            end else begin
              phase    <= PH_PLAYER;
              turn_out <= turn_out + 4'd1;
            end
          end else begin
            if (enemy_finished) begin
              pending <= 1'b1;
            end
            if (frame_start) begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end

        PH_GAME_OVER: begin
          if (start_go) begin
            phase        <= PH_TITLE;
            pending      <= 1'b0;
            turn_out     <= 4'd0;
            rotate_out   <= 2'b00;
            timeout_flag <= 1'b0;
            game_over    <= 1'b0;
          end else if (start_btn) begin
            pending <= 1'b1;
          end
        end

        default: begin
          phase     <= PH_TITLE;
          pending   <= 1'b0;
          frame_cnt <= 8'd0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turn_ctrl.sv
// tb/tb_turn_ctrl.sv - directed self-checking bench for turn_ctrl
module tb_turn_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic       start_btn;
  logic       player_done;
  logic [1:0] player_rotate;
  logic       enemy_busy;
  logic       enemy_finished;
  logic [3:0] state_out;
  logic [3:0] turn_out;
  logic [1:0] rotate_out;
  logic       timeout_flag;
  logic       game_over;

  int tests;
  int fails;

  localparam logic [3:0] S_TITLE = 4'b0001;
  localparam logic [3:0] S_PLAY  = 4'b0010;
  localparam logic [3:0] S_ANIM  = 4'b0100;
  localparam logic [3:0] S_ENEMY = 4'b1000;
  localparam logic [3:0] S_OVER  = 4'b1111;

  turn_ctrl #(
    .ANIM_FRAMES(2),
    .ENEMY_TIMEOUT_FRAMES(4),
    .MAX_TURN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .start_btn(start_btn),
    .player_done(player_done),
    .player_rotate(player_rotate),
    .enemy_busy(enemy_busy),
    .enemy_finished(enemy_finished),
    .state_out(state_out),
    .turn_out(turn_out),
    .rotate_out(rotate_out),
    .timeout_flag(timeout_flag),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of pulses from a negedge, let one posedge sample them, clear at the next negedge.
  task automatic step(input logic fs, input logic sb, input logic pd, input logic [1:0] rot, input logic ef);
    frame_start    = fs;
    start_btn      = sb;
    player_done    = pd;
    player_rotate  = rot;
    enemy_finished = ef;
    @(negedge clk);
    frame_start    = 1'b0;
    start_btn      = 1'b0;
    player_done    = 1'b0;
    enemy_finished = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    frame_start = 1'b0;
    start_btn = 1'b0;
    player_done = 1'b0;
    player_rotate = 2'b00;
    enemy_busy = 1'b0;
    enemy_finished = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 8'(state_out), 8'(S_TITLE));
    chk("rst_turn", 8'(turn_out), 8'd0);
    chk("rst_rot", 8'(rotate_out), 8'd0);
    chk("rst_to", 8'(timeout_flag), 8'd0);
    chk("rst_go", 8'(game_over), 8'd0);
    rst = 1'b1;

    // Idle frames keep the title screen.
    frames(5);
    chk("idle_state", 8'(state_out), 8'(S_TITLE));
    chk("idle_turn", 8'(turn_out), 8'd0);

    // start_btn is remembered until the frame boundary three cycles later.
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("start_wait", 8'(state_out), 8'(S_TITLE));
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    frames(1);
    chk("start_play", 8'(state_out), 8'(S_PLAY));

    // Two moves before the boundary: the last rotation wins.
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    chk("rot_last", 8'(rotate_out), 8'h2);
    chk("play_hold", 8'(state_out), 8'(S_PLAY));
    frames(1);
    chk("anim_state", 8'(state_out), 8'(S_ANIM));
    chk("anim_rot", 8'(rotate_out), 8'h2);

    // Triggers foreign to the animation phase are ignored.
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    chk("anim_rot_hold", 8'(rotate_out), 8'h2);
    frames(1);
    chk("anim_f1", 8'(state_out), 8'(S_ANIM));
    frames(1);
    chk("enemy_entry", 8'(state_out), 8'(S_ENEMY));

    // Finished while busy defers the exit.
    enemy_busy = 1'b1;
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    frames(1);
    chk("enemy_busy_hold", 8'(state_out), 8'(S_ENEMY));
    enemy_busy = 1'b0;
    frames(1);
    chk("enemy_exit_state", 8'(state_out), 8'(S_PLAY));
    chk("enemy_exit_turn", 8'(turn_out), 8'd1);
    chk("enemy_exit_to", 8'(timeout_flag), 8'd0);

    // Move and frame in the same cycle, then timeout in the second enemy phase ends the game.
    step(1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
    chk("same_cycle_anim", 8'(state_out), 8'(S_ANIM));
    chk("same_cycle_rot", 8'(rotate_out), 8'h1);
    frames(2);
    chk("enemy2_entry", 8'(state_out), 8'(S_ENEMY));
    enemy_busy = 1'b1;
    frames(3);
    chk("timeout_not_yet", 8'(state_out), 8'(S_ENEMY));
    chk("timeout_flag_pre", 8'(timeout_flag), 8'd0);
    frames(1);
    chk("over_state", 8'(state_out), 8'(S_OVER));
    chk("over_turn", 8'(turn_out), 8'd2);
    chk("over_go", 8'(game_over), 8'd1);
    chk("over_to", 8'(timeout_flag), 8'd1);
    enemy_busy = 1'b0;

    // Game over waits for start_btn only.
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    chk("over_hold", 8'(state_out), 8'(S_OVER));
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    frames(1);
    chk("restart_state", 8'(state_out), 8'(S_TITLE));
    chk("restart_turn", 8'(turn_out), 8'd0);
    chk("restart_rot", 8'(rotate_out), 8'd0);
    chk("restart_to", 8'(timeout_flag), 8'd0);
    chk("restart_go", 8'(game_over), 8'd0);

    // Second game: timeout on turn 0 continues play and the flag sticks.
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("g2_play", 8'(state_out), 8'(S_PLAY));
    step(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    frames(2);
    chk("g2_enemy", 8'(state_out), 8'(S_ENEMY));
    frames(4);
    chk("g2_to_state", 8'(state_out), 8'(S_PLAY));
    chk("g2_to_turn", 8'(turn_out), 8'd1);
    chk("g2_to_flag", 8'(timeout_flag), 8'd1);
    step(1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    frames(2);
    chk("g2_enemy2", 8'(state_out), 8'(S_ENEMY));
    chk("g2_flag_sticky", 8'(timeout_flag), 8'd1);

    // Reset between edges during a pending enemy handshake.
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", 8'(state_out), 8'(S_TITLE));
    chk("mid_rst_turn", 8'(turn_out), 8'd0);
    chk("mid_rst_to", 8'(timeout_flag), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    frames(1);
    chk("post_rst_title", 8'(state_out), 8'(S_TITLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turn_ctrl.md
Name: turn_ctrl

Overview:
- Game-flow sequencer that sits directly upstream of the enemy block and drives its state_in, turn_in and rotate_in.
- Steps through title, player turn, player animation, enemy turn and game-over phases.
- Waits on the enemy's busy/finished handshake during the enemy phase.
- Changes phase only on frame boundaries, so the renderers never see a mid-frame state change.

Parameters:
- ANIM_FRAMES, 30, frames spent in PLAYER_ANIM before the enemy phase starts (1..255).
- ENEMY_TIMEOUT_FRAMES, 120, frames allowed in ENEMY before a forced exit (1..255).
- MAX_TURN, 15, turn count at which the game ends (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- start_btn  in  1  one-cycle debounced pulse.
- player_done  in  1  one-cycle pulse: player committed a move.
- player_rotate  in  2  player-selected rotation, sampled together with player_done.
- enemy_busy  in  1  from the enemy block.
- enemy_finished  in  1  one-cycle pulse from the enemy block.
- state_out  out  4  phase code, feeds enemy state_in.
- turn_out  out  4  current turn number, feeds enemy turn_in.
- rotate_out  out  2  latched rotation, feeds enemy rotate_in.
- timeout_flag  out  1  sticky: an enemy phase was force-ended.
- game_over  out  1  high while in GAME_OVER.

Behaviour:
- Phase codes:
  - TITLE = 4'b0001
  - PLAYER = 4'b0010
  - PLAYER_ANIM = 4'b0100
  - ENEMY = 4'b1000
  - GAME_OVER = 4'b1111
  - No other value is ever driven.
- Reset (rst low, asynchronous), outputs:
  - state_out = TITLE
  - turn_out = 0
  - rotate_out = 0
  - timeout_flag = 0
  - game_over = 0
- Reset, internal state: all pending flags and frame counters = 0.
- Release of reset is synchronous to clk.
- Pending events: each trigger sets a one-bit pending flag.
  - TITLE: start_btn.
  - PLAYER: player_done.
  - ENEMY: enemy_finished.
  - GAME_OVER: start_btn.
- Phase transitions are registered and occur only on a cycle with frame_start = 1.
  - A transition requires that the trigger is pending, or is asserted in that same cycle.
  - state_out changes on the clock edge that samples frame_start, i.e. 1-cycle latency.
- Pending flags are cleared on every transition.
- Triggers that arrive in a phase that does not use them are ignored.
- TITLE -> PLAYER on start_btn.
- PLAYER -> PLAYER_ANIM on player_done.
  - rotate_out loads player_rotate in the cycle player_done = 1.
  - rotate_out is held until the next accepted player_done.
  - A second player_done before the transition overwrites rotate_out; the last one wins.
- PLAYER_ANIM:
  - An 8-bit frame counter clears on entry and increments on each frame_start.
  - When the counter = ANIM_FRAMES-1 on a frame_start, the block moves to ENEMY.
- ENEMY, normal exit:
  - Requires enemy_finished pending (or same-cycle) AND enemy_busy = 0 at frame_start.
  - If enemy_busy = 1, the exit is deferred to a later frame_start.
- ENEMY, timeout:
  - The frame counter clears on entry and counts frame_starts.
  - When the count reaches ENEMY_TIMEOUT_FRAMES-1 without a normal exit, the block takes the exit anyway, regardless of enemy_busy.
  - timeout_flag is set on that exit.
- ENEMY exit, turn counter:
  - If turn_out + 1 == MAX_TURN: go to GAME_OVER, turn_out = MAX_TURN.
  - Otherwise: go to PLAYER, turn_out increments by 1.
  - turn_out never wraps.
- GAME_OVER:
  - game_over = 1.
  - start_btn -> TITLE; turn_out = 0, rotate_out = 0, timeout_flag = 0 on that transition.
- Simultaneous events:
  - A trigger and frame_start in the same cycle means an immediate transition.
  - start_btn in non-TITLE/non-GAME_OVER phases has no effect.
- Reset asserted mid-phase: immediate return to reset values; any in-flight enemy handshake is discarded.

Test Plan:
- Reset, then 5 frame_starts with no buttons -> state_out = 4'b0001, turn_out = 0, all outputs 0.
- Start sequence:
  - Stimulus: start_btn pulse, then frame_start 3 cycles later; next, player_done with player_rotate = 2'b10, then a frame_start.
  - Response: state_out = 4'b0010 one cycle after that frame_start.
  - Response: after the next frame_start, state_out = 4'b0100 and rotate_out = 2'b10.
- Enemy handshake, ANIM_FRAMES = 2:
  - Stimulus: 2 frame_starts, then enemy_finished with enemy_busy = 1 at the next frame_start.
  - Response: state_out stays 4'b1000.
  - Stimulus: drop busy, then a frame_start.
  - Response: state_out = 4'b0010, turn_out = 1.
- Timeout, ENEMY_TIMEOUT_FRAMES = 4:
  - Stimulus: no enemy_finished.
  - Response: exit on the 4th frame_start in ENEMY; timeout_flag = 1 and stays 1 through later turns.
- End game, MAX_TURN = 2:
  - Stimulus: complete 2 enemy phases.
  - Response: state_out = 4'b1111, turn_out = 2, game_over = 1.
  - Stimulus: start_btn, then a frame_start.
  - Response: state_out = 4'b0001, turn_out = 0, timeout_flag = 0.
- Reset mid-ENEMY:
  - Stimulus: assert rst between clock edges.
  - Response: state_out = 4'b0001 immediately (before the next edge); no transition on the following frame_start without start_btn.
